ram_sweep_reader: RTL



---
 rtl/ram_sweep_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ram_sweep_reader.sv
// ram_sweep_reader
//
// Read-side companion to the switch-driven RAM write path. The block walks
// the 32x8 single-port synchronous RAM one address at a time. It holds each
// captured word on disp_addr/disp_data so the word can be shown on the HEX
// displays.
//
// Modes:
//   run=1 : auto-scan. Each address is held for DWELL cycles, so the
//           period per address is RD_LAT+1+DWELL cycles.
//   run=0 : manual. The block advances one address per step pulse sampled
//           in HOLD. A step seen during READ is dropped, not queued.
//
// Ports:
//   CLOCK_50       in   sole clock, rising edge
//   reset          in   synchronous, active-high
//   run            in   level, 1 = auto-scan, 0 = manual
//   step           in   single-cycle pulse, manual advance
//   ram_addr       out  [ADDR_W] address driven to the RAM
//   ram_wren       out  RAM write enable, tied to 0
//   ram_q          in   [DATA_W] RAM read data
//   disp_addr      out  [ADDR_W] address of the displayed word
//   disp_data      out  [DATA_W] displayed word
//   disp_valid     out  set once any word has been captured
//   wrap           out  one-cycle pulse when ram_addr goes from max to 0
//   checksum       out  [DATA_W] sum mod 2^DATA_W of one full sweep (optional)
//   checksum_valid out  a sweep checksum has been produced (optional)
//
// Optional feature: define RAM_SWEEP_READER_CHECKSUM_EN to add the sweep
// checksum outputs and the logic behind them.
module ram_sweep_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DWELL  = 50000000,
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
`ifdef RAM_SWEEP_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
  output logic              checksum_valid,
`endif
  output logic              wrap
);

  // Counter widths include the terminal value, so DWELL=1 and RD_LAT=1
  // still give a width of at least one bit.
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [DW_W-1:0]    dwell_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic               start;
  logic               advance;
  logic               capture;

  assign ram_wren = 1'b0;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (run || step) begin
          start     = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        // step is deliberately not looked at here, so a step during READ is lost.
        if (lat_cnt == LAT_LAST) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (run) advance = (dwell_cnt == DWELL_LAST);
        else     advance = step;
        if (advance) state_nxt = READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address issue: ram_addr stays put for the whole READ so the RAM output
  // settles on the word that CAPTURE takes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ram_addr <= '0;
      wrap     <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      wrap <= advance && (ram_addr == ADDR_MAX);
      if (start)        ram_addr <= '0;
      else if (advance) ram_addr <= ram_addr + ADDR_ONE;
      if (state == READ && state_nxt == READ) lat_cnt <= lat_cnt + LAT_W'(1);
      else                                    lat_cnt <= '0;
    end
  end

  // Dwell timing: the counter only runs in auto-mode HOLD. Any other state,
  // or run=0, holds it at 0, so when run returns the count starts over.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dwell_cnt <= '0;
    end else if (state == HOLD && run && !advance) begin
      dwell_cnt <= dwell_cnt + DW_W'(1);
    end else begin
      dwell_cnt <= '0;
    end
  end

  // Display capture: disp_* change only here, so they keep the previous
  // word while the next address is being read.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else if (capture) begin
      disp_addr  <= ram_addr;
      disp_data  <= ram_q;
      disp_valid <= 1'b1;
    end
  end

`ifdef RAM_SWEEP_READER_CHECKSUM_EN
  logic [DATA_W-1:0] acc;

  // Sweep checksum: the sweep always closes on the capture of the top
  // address, even when it did not begin at address 0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc            <= '0;
      checksum       <= '0;
      checksum_valid <= 1'b0;
    end else if (capture) begin
      if (ram_addr == ADDR_MAX) begin
        checksum       <= acc + ram_q;
        checksum_valid <= 1'b1;
        acc            <= '0;
      end else begin
        acc <= acc + ram_q;
      end
    end
  end
`endif

endmodule
